// File: rtl/score_row_packer.sv
// score_row_packer: requantizes signed 32-bit attention scores to int8 and
// packs them into LANES-wide rows for the softmax stage. One fill register
// collects the next row while the output register waits for the consumer.
module score_row_packer #(
   parameter int unsigned LANES = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 data_in_valid,
   output logic                 data_in_ready,
   input  logic [31:0]          in_data,
   input  logic [31:0]          in_scale,
   input  logic [7:0]           S,
   output logic                 data_out_valid,
   input  logic                 data_out_ready,
   output logic [8*LANES-1:0]   out_data
);

   localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned LW = $clog2(LANES + 1);
   localparam int unsigned PW = 65;
   localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);

   typedef enum logic {FILLING, HELD} state_t;

   state_t                  state;
   logic [LANES-1:0][7:0]   fill_q;
   logic [LANES-1:0][7:0]   fill_next;
   logic [LANES-1:0][7:0]   pad_src;
   logic [LANES-1:0][7:0]   pad_row;
   logic [CW-1:0]           cnt;
   logic [LW-1:0]           len_q;
   logic [LW-1:0]           len_now;
   logic [LW-1:0]           eff_len;
   logic [LW-1:0]           pad_len;
   logic signed [PW-1:0]    prod;
   logic signed [PW-1:0]    rnd;
   logic signed [PW-1:0]    q;
   logic [7:0]              sat;
   logic                    in_fire;
   logic                    slot_free;
   logic                    last;
   logic                    xfer_new;
   logic                    xfer_held;

   // Input is accepted whenever no completed row is parked in the fill register.
   assign data_in_ready = (state == FILLING);
   assign in_fire       = data_in_valid && data_in_ready;
   assign slot_free     = !data_out_valid || data_out_ready;

   // Effective row length: S clamped to 1..LANES, with 0 meaning a full row.
   always_comb begin
      len_now = LW'(LANES);
      if (S != 8'd0 && S <= 8'(LANES)) begin
         len_now = LW'(S);
      end
   end

   assign eff_len   = (cnt == '0) ? len_now : len_q;
   assign last      = in_fire && (cnt == CW'(eff_len - LW'(1)));
   assign xfer_new  = last && slot_free;
   assign xfer_held = (state == HELD) && slot_free;

   // Requant: signed x unsigned-scale product, round half up, saturate to int8.
   always_comb begin
      prod = $signed({{(PW-32){in_data[31]}}, in_data}) * $signed({{(PW-32){1'b0}}, in_scale});
      rnd  = prod + HALF;
      q    = rnd >>> FRAC;
      if (q > PW'(127)) begin
         sat = 8'h7f;
      end else if (q < -PW'(128)) begin
         sat = 8'h80;
      end else begin
         sat = q[7:0];
      end
   end

   // Fill register contents including the element accepted this cycle.
   always_comb begin
      fill_next = fill_q;
      if (in_fire) begin
         fill_next[cnt] = sat;
      end
   end

   // Row presented to the output register, lanes beyond the row length padded.
   always_comb begin
      pad_src = xfer_held ? fill_q : fill_next;
      pad_len = xfer_held ? len_q : eff_len;
      pad_row = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         pad_row[i] = (i < int'(pad_len)) ? pad_src[i] : 8'h80;
      end
   end

   // Fill/hold state, lane counter, row length and output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= FILLING;
         fill_q         <= '0;
         cnt            <= '0;
         len_q          <= LW'(LANES);
         data_out_valid <= 1'b0;
         out_data       <= '0;
      end else begin
         fill_q <= fill_next;
         if (in_fire) begin
            if (cnt == '0) begin
               len_q <= len_now;
            end
            cnt <= last ? '0 : CW'(cnt + 1'b1);
         end
         case (state)
            FILLING: if (last && !slot_free) state <= HELD;
            HELD:    if (slot_free)          state <= FILLING;
            default:                          state <= FILLING;
         endcase
         if (xfer_new || xfer_held) begin
            out_data       <= pad_row;
            data_out_valid <= 1'b1;
         end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_score_row_packer.sv
// Bench for score_row_packer: directed rows, expected rows queued by the
// stimulus and popped by an output monitor on each handshake.
module tb_score_row_packer;

   logic         clk;
   logic         rst;
   logic         data_in_valid;
   logic         data_in_ready;
   logic [31:0]  in_data;
   logic [31:0]  in_scale;
   logic [7:0]   S;
   logic         data_out_valid;
   logic         data_out_ready;
   logic [255:0] out_data;

   int           n_pass;
   int           n_total;
   logic [255:0] exp_q[$];
   logic [7:0]   eb[32];
   logic         stall_prev;
   logic [255:0] data_prev;
   logic [255:0] r1;
   logic [255:0] r2;

   score_row_packer #(.LANES(32), .FRAC(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in_valid  (data_in_valid),
      .data_in_ready  (data_in_ready),
      .in_data        (in_data),
      .in_scale       (in_scale),
      .S              (S),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .out_data       (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, want);
   endtask

   task automatic chkb(input string name, input logic act, input logic want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %b want %b", name, act, want);
   endtask

   // Expected row from eb[], lanes at or beyond len padded with 0x80.
   function automatic logic [255:0] row_of(input int len);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[8*i +: 8] = (i < len) ? eb[i] : 8'h80;
      return r;
   endfunction

   // Present one element and return 1 ns after the edge that accepts it.
   task automatic send(input logic [31:0] d, input logic [31:0] sc, input logic [7:0] s);
      logic acc;
      acc           = 1'b0;
      data_in_valid = 1'b1;
      in_data       = d;
      in_scale      = sc;
      S             = s;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = data_in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_total++;
         $display("FAIL accept_timeout: got ready 0 want 1 for data %h", d);
      end
   endtask

   task automatic idle(input int n);
      data_in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pop on handshake, stability while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chkb("hold_valid", data_out_valid, 1'b1);
            chk("hold_data", out_data, data_prev);
         end
         if (data_out_valid && data_out_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_row: got %h want none", out_data);
            end else begin
               chk("row", out_data, exp_q.pop_front());
            end
         end
         stall_prev = data_out_valid && !data_out_ready;
         data_prev  = out_data;
      end
   end

   initial begin
      n_pass = 0; n_total = 0; stall_prev = 1'b0; data_prev = '0;
      rst = 1'b0; data_in_valid = 1'b0; in_data = '0; in_scale = '0; S = '0;
      data_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chkb("reset_valid", data_out_valid, 1'b0);
      chk("reset_data", out_data, 256'd0);
      chkb("reset_in_ready", data_in_ready, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic row: 256*i scaled by 1/256 lands on lane value i.
      for (int i = 0; i < 32; i++) eb[i] = 8'(i);
      exp_q.push_back(row_of(32));
      for (int i = 0; i < 32; i++) begin
         send(32'(256 * i), 32'h0000_0100, 8'd32);
         if (i == 30) chkb("basic_not_early", data_out_valid, 1'b0);
      end
      chkb("basic_latency", data_out_valid, 1'b1);
      idle(3);

      // Rounding at scale 0.5: 3 -> 2, -3 -> -1.
      eb[0] = 8'h02; eb[1] = 8'hff;
      exp_q.push_back(row_of(2));
      send(32'd3, 32'h0000_8000, 8'd2);
      send(32'hffff_fffd, 32'h0000_8000, 8'd2);
      // Saturation at scale 1.0: 200 -> 127, -1000 -> -128.
      eb[0] = 8'h7f; eb[1] = 8'h80;
      exp_q.push_back(row_of(2));
      send(32'd200, 32'h0001_0000, 8'd2);
      send(32'(-1000), 32'h0001_0000, 8'd2);
      idle(3);

      // Padding: S = 5.
      for (int i = 0; i < 5; i++) eb[i] = 8'(i + 1);
      exp_q.push_back(row_of(5));
      for (int i = 0; i < 5; i++) begin
         send(32'(i + 1), 32'h0001_0000, 8'd5);
         if (i == 3) chkb("pad_not_early", data_out_valid, 1'b0);
      end
      chkb("pad_latency", data_out_valid, 1'b1);
      idle(3);

      // S = 0 means a full 32-lane row.
      for (int i = 0; i < 32; i++) eb[i] = 8'(-(i + 1));
      exp_q.push_back(row_of(32));
      for (int i = 0; i < 32; i++) begin
         send(32'(-(i + 1)), 32'h0001_0000, 8'd0);
         if (i == 30) chkb("s0_not_early", data_out_valid, 1'b0);
      end
      chkb("s0_complete", data_out_valid, 1'b1);
      idle(3);

      // Backpressure: two rows with the consumer stalled.
      data_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) eb[i] = 8'(i + 1);
      r1 = row_of(4);
      exp_q.push_back(r1);
      for (int i = 0; i < 4; i++) send(32'(i + 1), 32'h0001_0000, 8'd4);
      for (int i = 0; i < 4; i++) eb[i] = 8'(i + 9);
      r2 = row_of(4);
      exp_q.push_back(r2);
      for (int i = 0; i < 4; i++) send(32'(i + 9), 32'h0001_0000, 8'd4);
      idle(0);
      chkb("bp_in_ready_low", data_in_ready, 1'b0);
      chkb("bp_valid", data_out_valid, 1'b1);
      chk("bp_row1_held", out_data, r1);
      idle(3);
      chkb("bp_in_ready_still_low", data_in_ready, 1'b0);
      data_out_ready = 1'b1;
      @(posedge clk); #1;
      data_out_ready = 1'b0;
      chkb("bp_row2_valid", data_out_valid, 1'b1);
      chk("bp_row2_data", out_data, r2);
      chkb("bp_in_ready_back", data_in_ready, 1'b1);
      idle(2);
      data_out_ready = 1'b1;
      idle(3);

      // Back-to-back with S = 1: a row completes as the previous one leaves.
      for (int i = 0; i < 4; i++) begin
         eb[0] = 8'(i + 5);
         exp_q.push_back(row_of(1));
         send(32'(i + 5), 32'h0001_0000, 8'd1);
         chkb("b2b_valid_stays", data_out_valid, 1'b1);
      end
      // S = 4 continuous: one row per 4 elements, valid only after each 4th.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 4; i++) eb[i] = 8'(20 + 4 * r + i);
         exp_q.push_back(row_of(4));
         for (int i = 0; i < 4; i++) begin
            send(32'(20 + 4 * r + i), 32'h0001_0000, 8'd4);
            chkb("s4_valid_pattern", data_out_valid, (i == 3));
         end
      end
      idle(3);

      // Reset mid-row: 3 of 8 elements discarded, then a fresh row.
      for (int i = 0; i < 3; i++) send(32'(50 + i), 32'h0001_0000, 8'd8);
      idle(0);
      rst = 1'b0;
      idle(2);
      chkb("midrst_valid", data_out_valid, 1'b0);
      chkb("midrst_in_ready", data_in_ready, 1'b1);
      rst = 1'b1;
      idle(1);
      for (int i = 0; i < 8; i++) eb[i] = 8'(10 + i);
      exp_q.push_back(row_of(8));
      for (int i = 0; i < 8; i++) send(32'(10 + i), 32'h0001_0000, 8'd8);
      chkb("midrst_row_valid", data_out_valid, 1'b1);
      idle(5);

      chk("queue_empty", 256'(exp_q.size()), 256'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
